// File: rtl/sync_pkg.sv
// Shared types and default constants for the sync-chain peak detector.
package sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    WINDOW = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_DAT_W = 12;
  localparam int DEF_WIND  = 32;
  localparam int DEF_TS_W  = 16;
  localparam int DEF_HOLD  = 256;
  localparam int DEF_IDX_W = $clog2(DEF_WIND);

  // Peak report layout for the default configuration.
  typedef struct packed {
    logic [DEF_DAT_W-1:0] lvl;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_TS_W-1:0]  ts;
  } peak_rpt_t;

endpackage

// File: rtl/sync_peak_track.sv
// Running-maximum register: clear-loads on window start, replaces only on strictly greater level.
module sync_peak_track
  import sync_pkg::*;
#(
  parameter int pDAT_W = DEF_DAT_W,
  parameter int pIDX_W = DEF_IDX_W,
  parameter int pTS_W  = DEF_TS_W
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              load,
  input  logic              upd,
  input  logic [pDAT_W-1:0] lvl,
  input  logic [pIDX_W-1:0] idx,
  input  logic [pTS_W-1:0]  ts,
  output logic [pDAT_W-1:0] nxt_lvl,
  output logic [pIDX_W-1:0] nxt_idx,
  output logic [pTS_W-1:0]  nxt_ts
);

  logic [pDAT_W-1:0] max_lvl;
  logic [pIDX_W-1:0] max_idx;
  logic [pTS_W-1:0]  max_ts;

  // nxt_* already includes the sample being accepted, so the final window sample is reported too.
  always_comb begin
    nxt_lvl = max_lvl;
    nxt_idx = max_idx;
    nxt_ts  = max_ts;
    if (load) begin
      nxt_lvl = lvl;
      nxt_idx = '0;
      nxt_ts  = ts;
    end else if (upd && (lvl > max_lvl)) begin
      nxt_lvl = lvl;
      nxt_idx = idx;
      nxt_ts  = ts;
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      max_lvl <= '0;
      max_idx <= '0;
      max_ts  <= '0;
    end else begin
      max_lvl <= nxt_lvl;
      max_idx <= nxt_idx;
      max_ts  <= nxt_ts;
    end
  end

endmodule

// File: rtl/sync_peak_detect.sv
// Correlator peak detector: threshold arm, fixed-window max search, one-cycle report pulse.
// Optional post-report holdoff enabled by defining SYNC_PEAK_HOLDOFF_EN.
module sync_peak_detect
  import sync_pkg::*;
#(
  parameter int pDAT_W = DEF_DAT_W,
  parameter int pWIND  = DEF_WIND,
  parameter int pTS_W  = DEF_TS_W,
  parameter int pHOLD  = DEF_HOLD
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     iena,
  input  logic [pDAT_W-1:0]        icorr,
  input  logic [pDAT_W-1:0]        itrh_lvl,
  input  logic                     iarm,
  output logic                     osop,
  output logic [pDAT_W-1:0]        opeak_lvl,
  output logic [$clog2(pWIND)-1:0] opeak_idx,
  output logic [pTS_W-1:0]         opeak_ts,
  output logic                     obusy
);

  localparam int IDX_W = $clog2(pWIND);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(pWIND - 1);

  typedef struct packed {
    logic [pDAT_W-1:0] lvl;
    logic [IDX_W-1:0]  idx;
    logic [pTS_W-1:0]  ts;
  } rpt_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  win_cnt;
  logic [pTS_W-1:0]  ts_cnt;
  logic              load, upd, win_end;
  logic [pDAT_W-1:0] nxt_lvl;
  logic [IDX_W-1:0]  nxt_idx;
  logic [pTS_W-1:0]  nxt_ts;
  rpt_t              rpt;

`ifdef SYNC_PEAK_HOLDOFF_EN
  localparam int HOLD_W = (pHOLD > 1) ? $clog2(pHOLD) : 1;
  localparam logic [HOLD_W-1:0] HLAST = HOLD_W'(pHOLD - 1);
  logic [HOLD_W-1:0] hold_cnt;
`endif

  // win_cnt holds the offset of the next window sample; its wrap at LAST ends the window.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    upd       = 1'b0;
    win_end   = 1'b0;
    if (!iarm) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   state_nxt = SEARCH;
        SEARCH: if (iena && (icorr > itrh_lvl)) begin
          state_nxt = WINDOW;
          load      = 1'b1;
        end
        WINDOW: if (iena) begin
          upd = 1'b1;
          if (win_cnt == LAST) begin
            win_end = 1'b1;
`ifdef SYNC_PEAK_HOLDOFF_EN
            state_nxt = HOLD;
`else
            state_nxt = SEARCH;
`endif
          end
        end
`ifdef SYNC_PEAK_HOLDOFF_EN
        HOLD:   if (iena && (hold_cnt == HLAST)) state_nxt = SEARCH;
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state   <= IDLE;
      win_cnt <= '0;
      ts_cnt  <= '0;
      osop    <= 1'b0;
      obusy   <= 1'b0;
      rpt     <= '0;
    end else begin
      state <= state_nxt;
      if (iena) ts_cnt <= ts_cnt + pTS_W'(1);
      if (load) win_cnt <= IDX_W'(1);
      else if (upd) win_cnt <= win_cnt + IDX_W'(1);
      osop  <= win_end;
      obusy <= (state_nxt == WINDOW) || (state_nxt == HOLD);
      if (win_end) rpt <= '{lvl: nxt_lvl, idx: nxt_idx, ts: nxt_ts};
    end
  end

`ifdef SYNC_PEAK_HOLDOFF_EN
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) hold_cnt <= '0;
    else if (win_end) hold_cnt <= '0;
    else if ((state == HOLD) && iena) hold_cnt <= hold_cnt + HOLD_W'(1);
  end
`endif

  sync_peak_track #(
    .pDAT_W(pDAT_W),
    .pIDX_W(IDX_W),
    .pTS_W (pTS_W)
  ) u_track (
    .iclk   (iclk),
    .ireset (ireset),
    .load   (load),
    .upd    (upd),
    .lvl    (icorr),
    .idx    (win_cnt),
    .ts     (ts_cnt),
    .nxt_lvl(nxt_lvl),
    .nxt_idx(nxt_idx),
    .nxt_ts (nxt_ts)
  );

  assign opeak_lvl = rpt.lvl;
  assign opeak_idx = rpt.idx;
  assign opeak_ts  = rpt.ts;

endmodule

// File: tb/tb_sync_peak_detect.sv
// Bench for sync_peak_detect: scenario table, corner sequences and random stimulus vs a queue-based model.
module tb_sync_peak_detect;

  localparam int DW   = 12;
  localparam int WIND = 32;
  localparam int HOLD = 256;

  logic          iclk = 1'b0;
  logic          ireset = 1'b0;
  logic          iena = 1'b0;
  logic [DW-1:0] icorr = '0;
  logic [DW-1:0] itrh_lvl = 12'd100;
  logic          iarm = 1'b0;

  logic          osop, obusy, osop4, obusy4;
  logic [DW-1:0] opeak_lvl, opeak_lvl4;
  logic [4:0]    opeak_idx, opeak_idx4;
  logic [15:0]   opeak_ts;
  logic [3:0]    opeak_ts4;

  always #5 iclk = ~iclk;

  sync_peak_detect #(.pDAT_W(DW), .pWIND(WIND), .pTS_W(16), .pHOLD(HOLD)) dut (
    .iclk(iclk), .ireset(ireset), .iena(iena), .icorr(icorr), .itrh_lvl(itrh_lvl),
    .iarm(iarm), .osop(osop), .opeak_lvl(opeak_lvl), .opeak_idx(opeak_idx),
    .opeak_ts(opeak_ts), .obusy(obusy));

  sync_peak_detect #(.pDAT_W(DW), .pWIND(WIND), .pTS_W(4), .pHOLD(HOLD)) dut4 (
    .iclk(iclk), .ireset(ireset), .iena(iena), .icorr(icorr), .itrh_lvl(itrh_lvl),
    .iarm(iarm), .osop(osop4), .opeak_lvl(opeak_lvl4), .opeak_idx(opeak_idx4),
    .opeak_ts(opeak_ts4), .obusy(obusy4));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: a window is just the list of accepted samples; the report is its earliest maximum.
  bit [31:0] m_ts;
  bit        m_idle, m_active, m_hold;
  int        m_hold_left;
  int        q_lvl[$];
  bit [31:0] q_ts[$];
  bit        exp_sop, exp_busy;
  int        exp_lvl, exp_idx;
  bit [31:0] exp_ts;

  int        sop_cnt;
  int        cap_lvl, cap_idx, cap_ts, cap_ts4;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_idle = 1; m_active = 0; m_hold = 0; m_hold_left = 0;
    q_lvl.delete(); q_ts.delete();
    exp_sop = 0; exp_busy = 0; exp_lvl = 0; exp_idx = 0; exp_ts = 0;
  endtask

  task automatic model_step();
    int best;
    exp_sop = 0;
    if (!iarm) begin
      m_idle = 1; m_active = 0; m_hold = 0;
    end else if (m_idle) begin
      m_idle = 0;
    end else if (m_hold) begin
      if (iena) begin
        m_hold_left--;
        if (m_hold_left == 0) m_hold = 0;
      end
    end else if (m_active) begin
      if (iena) begin
        q_lvl.push_back(int'(icorr));
        q_ts.push_back(m_ts);
        if (q_lvl.size() == WIND) begin
          best = 0;
          for (int i = 1; i < WIND; i++) if (q_lvl[i] > q_lvl[best]) best = i;
          exp_lvl = q_lvl[best]; exp_idx = best; exp_ts = q_ts[best];
          exp_sop = 1; m_active = 0;
`ifdef SYNC_PEAK_HOLDOFF_EN
          m_hold = 1; m_hold_left = HOLD;
`endif
        end
      end
    end else if (iena && (icorr > itrh_lvl)) begin
      m_active = 1;
      q_lvl.delete(); q_ts.delete();
      q_lvl.push_back(int'(icorr));
      q_ts.push_back(m_ts);
    end
    if (iena) m_ts++;
    exp_busy = m_active || m_hold;
  endtask

  task automatic chk_outputs();
    chk("osop", osop, exp_sop);
    chk("obusy", obusy, exp_busy);
    chk("opeak_lvl", opeak_lvl, exp_lvl);
    chk("opeak_idx", opeak_idx, exp_idx);
    chk("opeak_ts", opeak_ts, exp_ts[15:0]);
    chk("osop_w4", osop4, exp_sop);
    chk("opeak_lvl_w4", opeak_lvl4, exp_lvl);
    chk("opeak_ts_w4", opeak_ts4, exp_ts[3:0]);
  endtask

  task automatic tick();
    model_step();
    @(posedge iclk);
    #1;
    chk_outputs();
    if (osop) begin
      sop_cnt++;
      cap_lvl = opeak_lvl; cap_idx = opeak_idx; cap_ts = opeak_ts; cap_ts4 = opeak_ts4;
    end
  endtask

  task automatic do_reset();
    ireset = 0;
    model_reset();
    #2;
    chk_outputs();
    @(posedge iclk);
    #1;
    ireset = 1;
  endtask

  task automatic feed(int val, int n);
    for (int i = 0; i < n; i++) begin
      iena = 1; icorr = DW'(val);
      tick();
    end
  endtask

  typedef struct {
    string nm;
    int    cross_at, peak_at, tie_at, peak_lvl;
    bit    stall;
    int    e_lvl, e_idx, e_ts, e_ts4;
  } scn_t;

  scn_t scn[6];

  task automatic run_scn(scn_t c);
    int s, cyc;
    do_reset();
    itrh_lvl = 12'd100; iarm = 1; s = 0; cyc = 0; sop_cnt = 0;
    while (s < c.cross_at + WIND + 4) begin
      iena = c.stall ? (cyc % 2 == 0) : 1'b1;
      if (!iena) icorr = 12'd4000;
      else if (s == c.peak_at || s == c.tie_at) icorr = DW'(c.peak_lvl);
      else if (s == c.cross_at) icorr = 12'd120;
      else if (s == c.cross_at - 1) icorr = 12'd100;
      else icorr = 12'd50;
      tick();
      if (iena) s++;
      cyc++;
    end
    chk({c.nm, "_sops"}, sop_cnt, 1);
    chk({c.nm, "_lvl"}, cap_lvl, c.e_lvl);
    chk({c.nm, "_idx"}, cap_idx, c.e_idx);
    chk({c.nm, "_ts"}, cap_ts, c.e_ts);
    chk({c.nm, "_ts4"}, cap_ts4, c.e_ts4);
  endtask

  initial begin
    int saved, k;
    scn[0] = '{"single", 10, 15, -1, 300, 0, 300, 5, 15, 15};
    scn[1] = '{"tie",    10, 13, 17, 200, 0, 200, 3, 13, 13};
    scn[2] = '{"stall",  10, 30, -1, 500, 1, 500, 20, 30, 14};
    scn[3] = '{"wrap",   12, 17, -1, 400, 0, 400, 5, 17, 1};
    scn[4] = '{"last",   10, 41, -1, 999, 0, 999, 31, 41, 9};
    scn[5] = '{"first",  10, 10, -1, 600, 0, 600, 0, 10, 10};

    do_reset();

    // single-peak timing: osop must appear right after sample 41 is accepted
    iarm = 1; itrh_lvl = 12'd100; sop_cnt = 0;
    for (int s = 0; s < 42; s++) begin
      iena = 1;
      icorr = (s == 10) ? 12'd120 : (s == 15) ? 12'd300 : 12'd50;
      tick();
      if (s == 11) chk("busy_rise", obusy, 1);
      if (s < 41) chk("sop_early", osop, 0);
    end
    chk("sop_on_time", osop, 1);
    feed(50, 1);
    chk("sop_one_cycle", osop, 0);
    chk("busy_fall", obusy, 0);

    foreach (scn[i]) run_scn(scn[i]);

    // abort at offset 20, then rearm and re-cross
    feed(50, HOLD + 10);
    saved = opeak_lvl;
    sop_cnt = 0;
    feed(130, 1);
    feed(50, 19);
    iarm = 0; iena = 1; icorr = 12'd900;
    tick();
    chk("abort_busy", obusy, 0);
    chk("abort_lvl", opeak_lvl, saved);
    iarm = 1;
    feed(50, 40);
    chk("abort_no_sop", sop_cnt, 0);
    feed(130, 1);
    feed(50, 1);
    feed(700, 1);
    feed(50, WIND);
    chk("rearm_sops", sop_cnt, 1);
    chk("rearm_lvl", cap_lvl, 700);
    chk("rearm_idx", cap_idx, 2);

    // holdoff: crossings 10 and 300 samples after a report
    feed(50, HOLD + 10);
    feed(130, 1);
    feed(50, WIND - 1);
    sop_cnt = 0;
    for (int i = 0; i < 340; i++) begin
      iena = 1;
      icorr = (i == 9) ? 12'd650 : (i == 299) ? 12'd800 : 12'd50;
      tick();
    end
`ifdef SYNC_PEAK_HOLDOFF_EN
    chk("hold_sops", sop_cnt, 1);
`else
    chk("hold_sops", sop_cnt, 2);
`endif
    chk("hold_lvl", cap_lvl, 800);

    // asynchronous reset in the middle of a window
    feed(50, HOLD + 10);
    feed(130, 1);
    feed(50, 10);
    chk("mid_busy", obusy, 1);
    do_reset();
    chk("mid_rst_busy", obusy, 0);

    // randomized traffic against the model
    itrh_lvl = DW'($urandom_range(2999, 2000));
    iarm = 1;
    for (int i = 0; i < 4000; i++) begin
      iena = ($urandom % 4) != 0;
      k = $urandom % 10;
      icorr = (k == 0) ? DW'($urandom_range(4095, 0)) : DW'($urandom_range(int'(itrh_lvl), 0));
      iarm = ($urandom % 300) != 0;
      if (i == 2000) itrh_lvl = DW'($urandom_range(3500, 500));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_peak_detect.md
# sync_peak_detect

Peak detector for the sign-correlator output stream in the sync chain. Consumes the per-sample correlation magnitude and its valid strobe, arms on a threshold crossing, searches a fixed window for the maximum, then emits a one-cycle start-of-packet pulse with peak level, in-window offset and sample timestamp. Its report drives the downstream frame-alignment and timing logic.

## Interface
- pDAT_W, 12, correlation magnitude width
- pWIND, 32, search window length in valid samples (power of two, ≥2)
- pTS_W, 16, sample timestamp width
- pHOLD, 256, holdoff length in valid samples (used only with SYNC_PEAK_HOLDOFF_EN)

- iclk  in  1  clock
- ireset  in  1  reset, asynchronous, active-low
- iena  in  1  sample valid (correlator enable)
- icorr  in  pDAT_W  unsigned correlation magnitude, valid when iena
- itrh_lvl  in  pDAT_W  detection threshold, quasi-static
- iarm  in  1  search enable; low forces IDLE
- osop  out  1  one-cycle peak report pulse
- opeak_lvl  out  pDAT_W  peak magnitude
- opeak_idx  out  $clog2(pWIND)  peak offset from window start
- opeak_ts  out  pTS_W  timestamp of peak sample
- obusy  out  1  high in WINDOW (and HOLD)

## Operation
- Timestamp counter: increments on every iena, in any state; wraps modulo 2^pTS_W; sample timestamp = counter value before increment.
- States: IDLE, SEARCH, WINDOW, HOLD (HOLD only with macro).
- IDLE: iarm high → SEARCH next cycle.
- SEARCH: on iena with icorr > itrh_lvl (strict) → WINDOW; that sample is window offset 0 and loads the running max (level, offset 0, timestamp).
- WINDOW: each iena increments offset; icorr > running max (strict; ties keep earliest) replaces max. iena low stalls; no sample counted.
- On acceptance of offset pWIND-1: running max latched into opeak_*, osop pulsed, FSM → HOLD (macro) or SEARCH. No sample lost: next cycle's sample is evaluated in the new state.
- iarm low in any state: → IDLE next cycle; WINDOW aborted with no osop; opeak_* keep previous values.
- Window counter exactly $clog2(pWIND) bits; wrap at pWIND-1 is the end condition.

## Timing
- Reset: state IDLE; osop, obusy, opeak_lvl, opeak_idx, opeak_ts, timestamp, window counter, running max all 0.
- All outputs registered.
- Crossing sample accepted at edge t with continuous iena: last window sample at edge t+pWIND-1; osop high for the cycle after that edge (one clock), opeak_* valid in that same cycle and held until next report.
- obusy rises the cycle after the crossing edge; falls with osop (no macro) or at end of HOLD.
- Threshold crossing and iarm deassertion in the same cycle: iarm wins, no WINDOW entry.
- Mid-operation reset: immediate return to reset values; osop never glitches high.

## Configuration
- SYNC_PEAK_HOLDOFF_EN defined: after report, HOLD ignores threshold for pHOLD valid samples (counted on iena), then → SEARCH; obusy high throughout.
- Undefined: report → SEARCH directly; pHOLD unused; HOLD state and counter absent.

## Structure
- Shared package sync_pkg: state enum (IDLE, SEARCH, WINDOW, HOLD), default window/holdoff constants, peak report struct (lvl, idx, ts).
- One sub-module: sync_peak_track — running max/offset/timestamp register with clear-load and strict-greater update; FSM and counters stay in top.

## Test plan
- Single peak: itrh_lvl=100, continuous iena, icorr=120 at sample 10, 300 at sample 15, else 50 → osop once, opeak_lvl=300, opeak_idx=5, opeak_ts=15, osop one cycle after sample 10+31 accepted.
- Tie: equal maxima 200 at offsets 3 and 7 → opeak_idx=3.
- Stalls: iena toggled 1/0 during window → osop after exactly pWIND valid samples; index counts valid samples only.
- Abort: iarm dropped at offset 20 → no osop, obusy low next cycle, opeak_* unchanged; rearm and re-cross → normal report.
- Holdoff (macro): second crossing 10 samples after report with pHOLD=256 → ignored; crossing at sample 300 after report → reported. Without macro: crossing at 10 → reported.
- Timestamp wrap: pTS_W=4, peak at sample 17 → opeak_ts=1.
